// File: rtl/inert_sens_ctrl.sv
// -----------------------------------------------------------------------------
// inert_sens_ctrl
//   Command sequencer sitting in front of the SPI monarch. After reset it waits
//   for the inertial sensor to power up and writes four configuration
//   registers. It then services the sensor's data-ready interrupt by reading
//   pitch rate and Z acceleration (low byte, then high byte) and publishing
//   both 16-bit words together with a one-cycle vld pulse.
//
// Ports
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   INT      in   sensor data-ready interrupt (async, level, active high)
//   done     in   SPI monarch transaction complete (level, held until next snd)
//   resp     in   SPI monarch response, only [7:0] carries data
//   snd      out  one-cycle SPI transaction request
//   cmd      out  SPI command word, stable from snd until done rises
//   ptch_rt  out  signed pitch rate {high, low}
//   az       out  signed Z acceleration {high, low}
//   vld      out  one-cycle pulse, ptch_rt/az updated this cycle
// -----------------------------------------------------------------------------
module inert_sens_ctrl #(
    parameter int PWR_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] resp,
    output logic        snd,
    output logic [15:0] cmd,
    output logic [15:0] ptch_rt,
    output logic [15:0] az,
    output logic        vld
);

    typedef enum logic [3:0] {
        PWR, CFG0, CFG1, CFG2, CFG3, IDLE, RPL, RPH, RAL, RAH, PUB
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_wait, w_wait_nxt;   // 0: ISSUE phase, 1: WAIT phase
    logic [PWR_W-1:0]  r_timer;
    logic              r_int_ff1, r_int_s;
    logic              r_done_ff;
    logic              w_done_rise;
    logic [7:0]        r_ptch_l, r_ptch_h, r_az_l, r_az_h;
    logic [15:0]       r_ptch_rt, r_az;
    logic              r_vld;
    logic              w_unused;

    // done is still high from the previous transaction when the next snd goes
    // out, so only its rising edge marks completion.
    assign w_done_rise = done & ~r_done_ff;
    assign w_unused    = &{1'b0, resp[15:8]};

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= PWR;
            r_wait  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        case (r_state)
            PWR: begin
                if (&r_timer) begin
                    w_state_nxt = CFG0;
                    w_wait_nxt  = 1'b0;
                end
            end
            IDLE: begin
                if (r_int_s) begin
                    w_state_nxt = RPL;
                    w_wait_nxt  = 1'b0;
                end
            end
            PUB: begin
                w_state_nxt = IDLE;
                w_wait_nxt  = 1'b0;
            end
            CFG0, CFG1, CFG2, CFG3, RPL, RPH, RAL, RAH: begin
                if (!r_wait) begin
                    w_wait_nxt = 1'b1;
                end else if (w_done_rise) begin
                    w_wait_nxt = 1'b0;
                    case (r_state)
                        CFG0:    w_state_nxt = CFG1;
                        CFG1:    w_state_nxt = CFG2;
                        CFG2:    w_state_nxt = CFG3;
                        CFG3:    w_state_nxt = IDLE;
                        RPL:     w_state_nxt = RPH;
                        RPH:     w_state_nxt = RAL;
                        RAL:     w_state_nxt = RAH;
                        RAH:     w_state_nxt = PUB;
                        default: w_state_nxt = PWR;
                    endcase
                end
            end
            // unused encodings recover through a full power-up
            default: begin
                w_state_nxt = PWR;
                w_wait_nxt  = 1'b0;
            end
        endcase
    end

    // ---------------- output logic ----------------
    // cmd is decoded from the state, so it holds through WAIT until the
    // state advances on the done edge.
    always_comb begin
        snd = 1'b0;
        cmd = 16'h0000;
        case (r_state)
            CFG0:    cmd = 16'h0D02;
            CFG1:    cmd = 16'h1053;
            CFG2:    cmd = 16'h1150;
            CFG3:    cmd = 16'h1460;
            RPL:     cmd = 16'hA200;
            RPH:     cmd = 16'hA300;
            RAL:     cmd = 16'hAC00;
            RAH:     cmd = 16'hAD00;
            default: cmd = 16'h0000;
        endcase
        snd = (cmd != 16'h0000) && !r_wait;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_int_ff1 <= 1'b0;
            r_int_s   <= 1'b0;
            r_done_ff <= 1'b0;
            r_timer   <= '0;
            r_ptch_l  <= 8'h00;
            r_ptch_h  <= 8'h00;
            r_az_l    <= 8'h00;
            r_az_h    <= 8'h00;
            r_ptch_rt <= 16'h0000;
            r_az      <= 16'h0000;
            r_vld     <= 1'b0;
        end else begin
            r_int_ff1 <= INT;
            r_int_s   <= r_int_ff1;
            r_done_ff <= done;
            r_vld     <= 1'b0;
            // timer saturates at all-ones and is frozen once PWR is left
            if (r_state == PWR && !(&r_timer))
                r_timer <= r_timer + 1'b1;
            if (r_wait && w_done_rise) begin
                case (r_state)
                    RPL:     r_ptch_l <= resp[7:0];
                    RPH:     r_ptch_h <= resp[7:0];
                    RAL:     r_az_l   <= resp[7:0];
                    RAH:     r_az_h   <= resp[7:0];
                    default: ;
                endcase
            end
            // both words change together so no mixed old/new bytes are seen
            if (r_state == PUB) begin
                r_ptch_rt <= {r_ptch_h, r_ptch_l};
                r_az      <= {r_az_h, r_az_l};
                r_vld     <= 1'b1;
            end
        end
    end

    assign ptch_rt = r_ptch_rt;
    assign az      = r_az;
    assign vld     = r_vld;

endmodule

// File: tb/tb_inert_sens_ctrl.sv
module tb_inert_sens_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        INT = 1'b0;
    logic        done = 1'b0;
    logic [15:0] resp = 16'h0000;
    logic        snd, vld;
    logic [15:0] cmd, ptch_rt, az;

    inert_sens_ctrl #(.PWR_W(4)) dut (
        .clk(clk), .rst(rst), .INT(INT), .done(done), .resp(resp),
        .snd(snd), .cmd(cmd), .ptch_rt(ptch_rt), .az(az), .vld(vld)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // posedges since reset release
    int pe = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) pe = 0;
        else     pe = pe + 1;
    end

    // stimulus knobs (written by the main sequence only)
    logic [7:0] tbl [4];
    int         stale = 0;
    localparam int LAT = 2;

    // model state (written by the checker only)
    logic [15:0] cfg_seq [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
    logic [15:0] rd_seq  [4] = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};
    int          m_idx = 0;
    logic [7:0]  m_b [4];
    bit          m_pend = 0;
    logic [15:0] m_pub_p = 0, m_pub_a = 0;
    bit          m_first = 1;
    int          m_first_pe = -1;
    logic [15:0] m_first_cmd = 0;
    int          n_snd = 0, n_vld = 0, n_rd_start = 0;
    // SPI serf state
    bit          s_busy = 0;
    logic [15:0] s_cmd = 0;
    int          s_cnt = 0, s_hold = 0;
    logic [15:0] exp_cmd;
    logic [7:0]  byt;

    // one process: check DUT outputs, then advance the SPI serf model
    always @(negedge clk) begin
        if (rst) begin
            check("reset_outputs", {15'd0, snd, cmd, ptch_rt, az, vld}, 64'd0);
            m_idx = 0; m_pend = 0; m_pub_p = 0; m_pub_a = 0; m_first = 1;
            s_busy = 0; done = 0; resp = 0;
        end else begin
            if (m_first) begin
                if (pe < 16) check("pwr_quiet", snd, 0);
                else         check("pwr_first_snd", snd, 1);
                if (snd || pe >= 16) begin
                    m_first = 0; m_first_pe = pe; m_first_cmd = cmd;
                end
            end
            if (snd) begin
                n_snd++;
                check("snd_while_busy", s_busy, 0);
                exp_cmd = (m_idx < 4) ? cfg_seq[m_idx] : rd_seq[(m_idx - 4) % 4];
                check("cmd_order", cmd, exp_cmd);
                if (cmd == 16'hA200) n_rd_start++;
                m_idx++;
                s_busy = 1; s_cmd = cmd; s_cnt = LAT; s_hold = stale;
                if (stale == 0) done = 0;
            end else if (s_busy) begin
                check("cmd_hold", cmd, s_cmd);
                if (s_hold > 0) begin
                    s_hold--;
                    if (s_hold == 0) done = 0;
                end else if (s_cnt > 0) begin
                    s_cnt--;
                end else begin
                    case (s_cmd[15:8])
                        8'hA2:   byt = tbl[0];
                        8'hA3:   byt = tbl[1];
                        8'hAC:   byt = tbl[2];
                        8'hAD:   byt = tbl[3];
                        default: byt = 8'h00;
                    endcase
                    case (s_cmd[15:8])
                        8'hA2: m_b[0] = byt;
                        8'hA3: m_b[1] = byt;
                        8'hAC: m_b[2] = byt;
                        8'hAD: begin m_b[3] = byt; m_pend = 1; end
                        default: ;
                    endcase
                    resp = {8'h5A, byt};   // upper byte is junk the DUT must ignore
                    done = 1; s_busy = 0;
                end
            end
            if (vld) begin
                n_vld++;
                check("vld_expected", m_pend, 1);
                check("ptch_rt", ptch_rt, {m_b[1], m_b[0]});
                check("az", az, {m_b[3], m_b[2]});
                m_pub_p = {m_b[1], m_b[0]}; m_pub_a = {m_b[3], m_b[2]}; m_pend = 0;
            end else begin
                check("outputs_stable", {ptch_rt, az}, {m_pub_p, m_pub_a});
            end
        end
    end

    int to;

    task automatic settle_no_activity(input int cyc, input int exp_snd, input int exp_vld);
        repeat (cyc) @(negedge clk);
        #1;
        check("snd_count", n_snd, exp_snd);
        check("vld_count", n_vld, exp_vld);
    endtask

    initial begin
        tbl = '{8'h00, 8'h00, 8'h00, 8'h00};
        repeat (3) @(negedge clk);
        #2 rst = 0;

        // configuration, then idle with INT low
        to = 0;
        while (!(m_idx >= 4 && !s_busy) && to < 500) begin @(negedge clk); #1; to++; end
        check("cfg_timeout", to < 500, 1);
        check("first_cmd", m_first_cmd, 16'h0D02);
        check("first_snd_cycle", m_first_pe, 16);
        settle_no_activity(20, 4, 0);

        // single read
        tbl = '{8'h34, 8'h12, 8'hCD, 8'hAB};
        INT = 1;
        to = 0;
        while (n_rd_start < 1 && to < 200) begin @(negedge clk); #1; to++; end
        INT = 0;
        to = 0;
        while (n_vld < 1 && to < 200) begin @(negedge clk); #1; to++; end
        check("read1_timeout", to < 200, 1);
        check("read1_ptch", ptch_rt, 16'h1234);
        check("read1_az", az, 16'hABCD);
        settle_no_activity(20, 8, 1);

        // sign / byte order with done held high past snd
        tbl = '{8'h00, 8'h80, 8'hFF, 8'hFF};
        stale = 3;
        INT = 1;
        to = 0;
        while (n_rd_start < 2 && to < 200) begin @(negedge clk); #1; to++; end
        INT = 0;
        to = 0;
        while (n_vld < 2 && to < 300) begin @(negedge clk); #1; to++; end
        check("read2_timeout", to < 300, 1);
        check("read2_ptch", ptch_rt, 16'h8000);
        check("read2_az", az, 16'hFFFF);
        settle_no_activity(20, 12, 2);
        stale = 0;

        // INT held through IDLE re-entry: two back-to-back sets
        tbl = '{8'h11, 8'h22, 8'h33, 8'h44};
        INT = 1;
        to = 0;
        while (n_rd_start < 4 && to < 400) begin @(negedge clk); #1; to++; end
        INT = 0;
        to = 0;
        while (n_vld < 4 && to < 300) begin @(negedge clk); #1; to++; end
        check("read34_timeout", to < 300, 1);
        check("read4_ptch", ptch_rt, 16'h2211);
        check("read4_az", az, 16'h4433);
        settle_no_activity(20, 20, 4);

        // reset during the RPH wait phase
        INT = 1;
        to = 0;
        while (!(s_busy && s_cmd == 16'hA300) && to < 200) begin @(negedge clk); #1; to++; end
        check("rph_timeout", to < 200, 1);
        @(negedge clk);
        #3 rst = 1;
        INT = 0;
        repeat (3) @(negedge clk);
        #2 rst = 0;
        to = 0;
        while (!(m_idx >= 4 && !s_busy) && to < 500) begin @(negedge clk); #1; to++; end
        check("recfg_timeout", to < 500, 1);
        check("recfg_first_cmd", m_first_cmd, 16'h0D02);
        check("recfg_first_snd_cycle", m_first_pe, 16);
        check("recfg_ptch_zero", ptch_rt, 16'h0000);
        check("recfg_az_zero", az, 16'h0000);
        settle_no_activity(20, 26, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inert_sens_ctrl.md
Name: inert_sens_ctrl

Overview:
- Command sequencer directly upstream of the SPI monarch; it is the only block that drives that monarch's snd/cmd and the only consumer of its done/resp.
- After reset it waits for the inertial sensor to power up, then writes four configuration registers.
- After configuration, each time the sensor's data-ready interrupt is seen, it reads pitch-rate and Z-acceleration (low/high bytes), assembles two 16-bit words and pulses vld to the downstream integrator.

Parameters:
- PWR_W, 16, width of the power-up wait timer; the wait ends when the timer is all-ones (2^PWR_W-1 cycles). Benches use 4.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- INT  in  1  sensor data-ready interrupt, asynchronous, active high
- done  in  1  SPI monarch transaction complete; level, held until next snd
- resp  in  16  SPI monarch response; only [7:0] used
- snd  out  1  one-cycle request to start SPI transaction
- cmd  out  16  SPI command word, stable from snd until done rises
- ptch_rt  out  16  signed pitch rate, {high byte, low byte}
- az  out  16  signed Z acceleration, {high byte, low byte}
- vld  out  1  one-cycle pulse: ptch_rt/az updated this cycle

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high.
- Reset values: snd=0, cmd=16'h0000, ptch_rt=16'h0000, az=16'h0000, vld=0, state=PWR, timer=0, byte holding registers=0, synchronizer flops=0.
- INT passes through a 2-flop synchronizer; the FSM uses the second flop (INT_s) only.
- done is flopped once (done_ff). Transaction complete = done & ~done_ff (rising edge). Level done is never used, because it is still high from the previous transaction when snd is issued.
- States: PWR, CFG0, CFG1, CFG2, CFG3, IDLE, RPL, RPH, RAL, RAH, PUB. Each command state has two phases: ISSUE, then WAIT.
  - ISSUE: snd=1 for exactly one cycle and cmd is loaded.
  - WAIT: the FSM holds cmd and waits for the done rising edge.
  - No snd is issued while in WAIT.
- Command words: CFG0 16'h0D02, CFG1 16'h1053, CFG2 16'h1150, CFG3 16'h1460, RPL 16'hA200, RPH 16'hA300, RAL 16'hAC00, RAH 16'hAD00.
- PWR: timer increments every cycle; when timer==all-ones, go to CFG0 ISSUE on the next cycle. The timer is frozen after PWR.
- CFG0 through CFG3 each advance on their done edge. CFG3 done edge goes to IDLE. resp is ignored during configuration.
- IDLE: if INT_s=1, go to RPL ISSUE. INT_s is a level; the sensor clears INT when data is read. Re-entry into IDLE with INT_s still high starts another read set immediately.
- Read states capture resp[7:0] into a holding register in the same cycle as their done edge:
  - RPL done edge: capture ptch_l.
  - RPH done edge: capture ptch_h.
  - RAL done edge: capture az_l.
  - RAH done edge: capture az_h, then go to PUB.
- PUB (1 cycle): ptch_rt<={ptch_h,ptch_l}, az<={az_h,az_l}, vld=1, then go to IDLE.
  - Outputs update only in PUB, so ptch_rt/az never show mixed old/new bytes.
  - vld is registered and high for exactly one cycle per read set.
- Latency: IDLE with INT_s high to vld is 4 SPI transactions + 4 ISSUE cycles + 1 PUB cycle.
- INT edges during PWR, CFGx or a read set are not queued; only the IDLE level test matters.
- A done edge arriving in any state other than WAIT is ignored (no spurious advance).
- Reset asserted mid-transaction: return to PWR immediately and repeat the full power-up and config sequence. The SPI monarch is reset by the same signal.
- No timeout on done: the FSM waits indefinitely. This is a deliberate decision.

Test Plan:
- Power-up (PWR_W=4): reset release -> snd stays 0 for 15 cycles; then first snd with cmd=16'h0D02; no snd before that.
- Config sequence (SPI serf model): 4 snd pulses with cmd 0D02, 1053, 1150, 1460 in order, each issued only after the prior done edge; vld=0 throughout.
- Single read (INT held high, serf returns A2→8'h34, A3→8'h12, AC→8'hCD, AD→8'hAB):
  - cmds are A200, A300, AC00, AD00;
  - then ptch_rt=16'h1234, az=16'hABCD, with a 1-cycle vld.
- Sign and byte order (serf returns A2→8'h00, A3→8'h80, AC→8'hFF, AD→8'hFF) -> ptch_rt=16'h8000, az=16'hFFFF.
- Stale done (serf holds done high between transactions; second snd issued while done=1) -> FSM advances only on the next 0→1 edge; no skipped command.
- Reset mid-read (rst pulsed during the RPH WAIT phase):
  - outputs return to reset values and vld stays 0;
  - the sequence restarts at PWR and re-sends 0D02 after 15 cycles.
